flop_to_bcd: RTL and testbench

Sequential decoder for the 13-bit float word produced by the float adder. It captures one word on a start strobe, extracts the truncated integer magnitude, and converts it to five BCD digits by shift-and-add-3 (double dabble), one bit per clock. It sits between the arithmetic datapath and the seven-segment display driver, and pulses `done` when a fresh decimal result is valid.

---
 rtl/flop_to_bcd.sv | 142 ++++++++++++++
 tb/tb_flop_to_bcd.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/flop_to_bcd.sv
// flop_to_bcd: captures a 13-bit float word, truncates it to a 16-bit integer
// magnitude and converts that to five BCD digits with shift-and-add-3, one bit
// per clock. A result appears exactly 17 clocks after the accepting start edge.
module flop_to_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] operand,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic        neg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_bin;
  logic [19:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_sign;

  logic [22:0] w_shifted;
  logic [15:0] w_mag;
  logic        w_sign_in;
  logic        w_accept;
  logic [19:0] w_acc_adj;
  logic [19:0] w_acc_next;

  // Add 3 to every BCD digit that is 5 or more, ahead of the doubling shift.
  function automatic logic [19:0] add3_digits(input logic [19:0] a);
    logic [19:0] res;
    res = a;
    for (int i = 0; i < 5; i++) begin
      if (a[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = a[i*4 +: 4];
      end
    end
    return res;
  endfunction

  // Operand decode: integer magnitude and sign; negative zero becomes positive.
  always_comb begin
    w_shifted = {15'd0, operand[11:4]} << operand[3:0];
    w_mag     = w_shifted[22:7];
    w_sign_in = operand[12] & (w_mag != 16'd0);
  end

  // One double-dabble step on the current scratch registers.
  always_comb begin
    w_acc_adj  = add3_digits(r_acc);
    w_acc_next = {w_acc_adj[18:0], r_bin[15]};
  end

  // A new operand is accepted only when no conversion is running.
  always_comb begin
    w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  end

  // Next-state logic; CONVERT leaves after the shift that takes cnt from 1 to 0.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CONVERT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CONVERT: begin
        if (r_cnt <= 5'd1) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CONVERT;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_CONVERT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register and registered status flags derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      busy    <= (w_state_next == S_CONVERT);
      done    <= (w_state_next == S_DONE);
    end
  end

  // Conversion scratch: load on accept, shift once per CONVERT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin  <= 16'd0;
      r_acc  <= 20'd0;
      r_cnt  <= 5'd0;
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_bin  <= w_mag;
      r_acc  <= 20'd0;
      r_cnt  <= 5'd16;
      r_sign <= w_sign_in;
    end else if (r_state == S_CONVERT) begin
      r_bin  <= {r_bin[14:0], 1'b0};
      r_acc  <= w_acc_next;
      r_cnt  <= r_cnt - 5'd1;
    end
  end

  // Result outputs update only on entry to DONE so partial digits never show.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd <= 20'd0;
      neg <= 1'b0;
    end else if ((r_state == S_CONVERT) && (w_state_next == S_DONE)) begin
      bcd <= w_acc_next;
      neg <= r_sign;
    end
  end

endmodule

// File: tb/tb_flop_to_bcd.sv
// Directed bench for flop_to_bcd: table of single conversions plus hand-written
// sequences for start-while-busy, back-to-back starts and reset mid-conversion.
module tb_flop_to_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] operand;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        neg;

  int n_total;
  int n_pass;
  logic [19:0] last_bcd;

  typedef struct {
    logic [12:0] op;
    logic [19:0] exp_bcd;
    logic        exp_neg;
  } vec_t;

  vec_t vecs[12];

  flop_to_bcd dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .operand(operand),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .neg    (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end else begin
      n_pass++;
    end
  endtask

  // One conversion. If preloaded, start/operand are already driven high.
  // extra_at: cycle index (edges since accept) at which a stray start is raised.
  // chain_en: raise start with chain_op in the DONE cycle and return at once.
  task automatic do_conv(input string name, input logic [12:0] op,
                         input logic [19:0] eb, input logic en,
                         input int extra_at, input logic [12:0] extra_op,
                         input bit chain_en, input logic [12:0] chain_op,
                         input bit preloaded);
    int n;
    int busy_cnt;
    int hold_err;
    bit seen;
    if (!preloaded) begin
      @(negedge clk);
      operand = op;
      start   = 1'b1;
    end
    @(posedge clk);
    n = 1;
    busy_cnt = 0;
    hold_err = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (n == extra_at) begin
        start   = 1'b1;
        operand = extra_op;
      end else begin
        start   = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (bcd !== last_bcd) hold_err++;
        @(posedge clk);
        n++;
      end
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'd17);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    chk({name, "_hold"}, 32'(hold_err), 32'd0);
    chk({name, "_bcd"}, 32'(bcd), 32'(eb));
    chk({name, "_neg"}, 32'(neg), 32'(en));
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    last_bcd = eb;
    if (chain_en) begin
      start   = 1'b1;
      operand = chain_op;
    end else begin
      start = 1'b0;
      @(negedge clk);
      chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int dcount;
    n_total  = 0;
    n_pass   = 0;
    last_bcd = 20'd0;
    start    = 1'b0;
    operand  = 13'd0;
    reset    = 1'b1;

    vecs[0]  = '{13'h0807, 20'h00128, 1'b0};
    vecs[1]  = '{13'h0FFF, 20'h65280, 1'b0};
    vecs[2]  = '{13'h1C02, 20'h00006, 1'b1};
    vecs[3]  = '{13'h17F0, 20'h00000, 1'b0};
    vecs[4]  = '{13'h1FFF, 20'h65280, 1'b1};
    vecs[5]  = '{13'h0010, 20'h00000, 1'b0};
    vecs[6]  = '{13'h0B1A, 20'h01416, 1'b0};
    vecs[7]  = '{13'h1640, 20'h00000, 1'b0};
    vecs[8]  = '{13'h0F47, 20'h00244, 1'b0};
    vecs[9]  = '{13'h1E89, 20'h00928, 1'b1};
    vecs[10] = '{13'h0018, 20'h00002, 1'b0};
    vecs[11] = '{13'h0A5D, 20'h10560, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    reset = 1'b0;
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_done_without_start", 32'(dcount), 32'd0);

    // Table-driven single conversions
    for (int i = 0; i < 12; i++) begin
      do_conv($sformatf("vec%0d", i), vecs[i].op, vecs[i].exp_bcd, vecs[i].exp_neg,
              -1, 13'd0, 1'b0, 13'd0, 1'b0);
      repeat (2) @(negedge clk);
    end

    // Start while busy is ignored
    do_conv("ign_busy", 13'h0807, 20'h00128, 1'b0, 3, 13'h0FFF, 1'b0, 13'd0, 1'b0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("ign_busy_no_second_done", 32'(dcount), 32'd0);
    chk("ign_busy_bcd_held", 32'(bcd), 32'h00128);

    // Back-to-back: start held high in the DONE cycle
    do_conv("b2b_first", 13'h1C02, 20'h00006, 1'b1, -1, 13'd0, 1'b1, 13'h0FFF, 1'b0);
    do_conv("b2b_second", 13'h0FFF, 20'h65280, 1'b0, -1, 13'd0, 1'b0, 13'd0, 1'b1);

    // Reset in the middle of a conversion
    @(negedge clk);
    operand = 13'h0807;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy_before_reset", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_busy_async", 32'(busy), 32'd0);
    chk("mid_bcd_cleared", 32'(bcd), 32'd0);
    chk("mid_neg_cleared", 32'(neg), 32'd0);
    last_bcd = 20'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mid_no_done", 32'(dcount), 32'd0);
    chk("mid_bcd_still_zero", 32'(bcd), 32'd0);
    do_conv("after_reset", 13'h1C02, 20'h00006, 1'b1, -1, 13'd0, 1'b0, 13'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
